// File: rtl/zoom_engine_if.sv
// Memory-side bundle of the zoom engine: the source ROM read port and the frame RAM write port.
interface zoom_engine_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;

    modport master (output rd_addr, wr_addr, wr_data, wr_en, input rd_data);
    modport slave  (input rd_addr, wr_addr, wr_data, wr_en, output rd_data);
endinterface

// File: rtl/zoom_engine.sv
// Zoom engine: writes a zoomed-in, decimated or block-averaged copy of a source ROM image to a frame RAM.
// Block averaging is built only when ZOOM_ENGINE_AVG_EN is defined; otherwise algorithm 11 decimates.
module zoom_engine #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           zoom_level,
    input  logic [1:0]           algorithm_select,
    zoom_engine_if.master        mem,
    output logic                 done,
    output logic                 busy
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, WAIT_LOW} state_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x, nx;
    logic [YW-1:0]     y, ny;
    logic [3:0]        sub, last_sub;
    logic [1:0]        fs;
    logic              zin;
    logic              avg_m;
    logic              x_last, frame_last;
    logic              cur_active, nxt_active, start_active;
    logic [ADDR_W-1:0] rd_hold, rd_calc;
    logic [7:0]        pix;
    logic              wr_en;

    // fs is log2 of the zoom factor; zin covers 1x and zoom-in, which share the centred-crop mapping.
    function automatic logic [1:0] level_fs(input logic [2:0] lvl);
        case (lvl)
            3'd0, 3'd4: return 2'd2;
            3'd1, 3'd3: return 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

    function automatic logic level_zin(input logic [2:0] lvl);
        return !(lvl == 3'd0 || lvl == 3'd1);
    endfunction

    function automatic int org(input int size, input logic [1:0] f_s);
        return (size - (size >> f_s)) / 2;
    endfunction

    function automatic logic is_active(input logic [1:0] f_s, input logic z_in,
                                       input int px, input int py);
        int ox, oy;
        ox = org(IMG_W, f_s);
        oy = org(IMG_H, f_s);
        return z_in || (px >= ox && px < ox + (IMG_W >> f_s) &&
                        py >= oy && py < oy + (IMG_H >> f_s));
    endfunction

    function automatic logic [ADDR_W-1:0] src_addr(input logic [1:0] f_s, input logic z_in,
                                                   input int px, input int py, input int s);
        int sx, sy;
        if (z_in) begin
            sx = org(IMG_W, f_s) + (px >> f_s);
            sy = org(IMG_H, f_s) + (py >> f_s);
        end else begin
            sx = ((px - org(IMG_W, f_s)) << f_s) + (s & ((1 << f_s) - 1));
            sy = ((py - org(IMG_H, f_s)) << f_s) + (s >> f_s);
        end
        return ADDR_W'(sy * IMG_W + sx);
    endfunction

    assign x_last       = (x == XW'(IMG_W - 1));
    assign frame_last   = x_last && (y == YW'(IMG_H - 1));
    assign nx           = x_last ? '0 : x + 1'b1;
    assign ny           = frame_last ? '0 : (x_last ? y + 1'b1 : y);
    assign last_sub     = avg_m ? 4'((5'd1 << {fs, 1'b0}) - 5'd1) : 4'd0;
    assign cur_active   = is_active(fs, zin, int'(x), int'(y));
    assign nxt_active   = is_active(fs, zin, int'(nx), int'(ny));
    assign start_active = is_active(level_fs(zoom_level), level_zin(zoom_level), 0, 0);
    assign rd_calc      = src_addr(fs, zin, int'(x), int'(y), int'(sub));

`ifdef ZOOM_ENGINE_AVG_EN
    logic [11:0] acc;

    function automatic logic [7:0] block_mean(input logic [11:0] sum, input logic [1:0] f_s);
        return 8'(sum >> {f_s, 1'b0});
    endfunction

    // The first READ cycle has no returned data yet, so accumulation lags the read index by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            avg_m <= 1'b0;
            acc   <= '0;
        end else if (state == IDLE && enable) begin
            avg_m <= !level_zin(zoom_level) && (algorithm_select == 2'b11);
            acc   <= '0;
        end else if (state == READ && sub != 4'd0) begin
            acc <= acc + 12'(mem.rd_data);
        end else if (state == WRITE) begin
            acc <= '0;
        end
    end

    assign pix = avg_m ? block_mean(acc + 12'(mem.rd_data), fs) : mem.rd_data;
`else
    logic unused_alg;

    assign avg_m      = 1'b0;
    assign unused_alg = ^algorithm_select;
    assign pix        = mem.rd_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            sub     <= '0;
            fs      <= '0;
            zin     <= 1'b0;
            rd_hold <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (enable) begin
                    fs  <= level_fs(zoom_level);
                    zin <= level_zin(zoom_level);
                    x   <= '0;
                    y   <= '0;
                    sub <= '0;
                end
                READ: begin
                    rd_hold <= rd_calc;
                    if (sub != last_sub) sub <= sub + 1'b1;
                end
                WRITE: begin
                    sub <= '0;
                    x   <= nx;
                    y   <= ny;
                end
                default: ;
            endcase
        end
    end

    // Fill pixels skip READ entirely, so the next-state choice looks ahead at the next pixel.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE:     if (enable) state_nxt = start_active ? READ : WRITE;
            READ: begin
                busy = 1'b1;
                if (sub == last_sub) state_nxt = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (frame_last)      state_nxt = DONE;
                else if (nxt_active) state_nxt = READ;
                else                 state_nxt = WRITE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: if (!enable) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign mem.rd_addr = (state == READ) ? rd_calc : rd_hold;
    assign mem.wr_addr = ADDR_W'(int'(y) * IMG_W + int'(x));
    assign mem.wr_data = (state == WRITE && cur_active) ? pix : 8'h00;
    assign mem.wr_en   = wr_en;
endmodule

// File: tb/tb_zoom_engine.sv
// Self-checking bench for zoom_engine: random ROM contents against a pixel/timing reference model.
module tb_zoom_engine;
    localparam int W = 160;
    localparam int H = 120;
    localparam int NPIX = W * H;
    localparam int HIST = 131072;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] zoom_level = 3'd2;
    logic [1:0] algorithm_select = 2'b00;
    logic       done, busy;

    zoom_engine_if #(.ADDR_W(15)) bus ();

    zoom_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(15)) dut (
        .clk(clk), .reset(reset), .enable(enable), .zoom_level(zoom_level),
        .algorithm_select(algorithm_select), .mem(bus), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:NPIX-1];
    logic [14:0] rd_hist [0:HIST-1];
    int cyc = 0;
    int done_cnt = 0;
    int checks = 0;
    int failures = 0;
    int wl_addr[$], wl_data[$], wl_cyc[$];
    int exp_addr[$], exp_data[$], exp_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.rd_data <= (int'(bus.rd_addr) < NPIX) ? rom[bus.rd_addr] : 8'h00;
    end

    always @(negedge clk) begin
        if (cyc < HIST) rd_hist[cyc] = bus.rd_addr;
        if (bus.wr_en === 1'b1) begin
            wl_addr.push_back(int'(bus.wr_addr));
            wl_data.push_back(int'(bus.wr_data));
            wl_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: zoom factor, centred crop/active window, decimation or truncated FxF mean.
    task automatic model_pixel(input int lvl, input int alg, input int dx, input int dy,
                               output int d, output int c);
        int f, ox, oy, bx, by, sum;
        bit avg;
        f = (lvl == 0 || lvl == 4) ? 4 : ((lvl == 1 || lvl == 3) ? 2 : 1);
        ox = (W - W / f) / 2;
        oy = (H - H / f) / 2;
`ifdef ZOOM_ENGINE_AVG_EN
        avg = (lvl < 2) && (alg == 3);
`else
        avg = 1'b0;
`endif
        if (lvl >= 2) begin
            d = int'(rom[(oy + dy / f) * W + ox + dx / f]);
            c = 2;
        end else if (dx < ox || dx >= ox + W / f || dy < oy || dy >= oy + H / f) begin
            d = 0;
            c = 1;
        end else begin
            bx = (dx - ox) * f;
            by = (dy - oy) * f;
            if (avg) begin
                sum = 0;
                for (int j = 0; j < f; j++)
                    for (int i = 0; i < f; i++) sum += int'(rom[(by + j) * W + bx + i]);
                d = sum / (f * f);
                c = f * f + 1;
            end else begin
                d = int'(rom[by * W + bx]);
                c = 2;
            end
        end
    endtask

    task automatic build_exp(input int lvl, input int alg, input int s, input int n);
        int t, d, c;
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        t = s + 1;
        for (int i = 0; i < n && i < NPIX; i++) begin
            model_pixel(lvl, alg, i % W, i / W, d, c);
            exp_addr.push_back(i);
            exp_data.push_back(d);
            exp_cyc.push_back(t + c - 1);
            t += c;
        end
    endtask

    task automatic start_frame(input int lvl, input int alg, output int s);
        wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
        done_cnt = 0;
        zoom_level = 3'(lvl);
        algorithm_select = 2'(alg);
        enable = 1'b1;
        s = cyc;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wl_addr.size() < n && done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic abort_frame();
        enable = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic randomize_rom();
        foreach (rom[a]) rom[a] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rd_addr !== 15'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
        checks++; if (bus.wr_addr !== 15'd0) begin failures++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_data: got %0d want 0", bus.wr_data); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_copy();
        int s, bad, first;
        foreach (rom[a]) rom[a] = 8'(a);
        start_frame(2, int'($urandom_range(0, 3)), s);
        wait_writes(NPIX + 1, 45000);
        checks++;
        if (done_cnt == 0) begin failures++; $display("FAIL copy_done_timeout: writes=%0d want %0d", wl_addr.size(), NPIX); end
        bad = 0; first = -1;
        foreach (wl_addr[i]) if (wl_data[i] !== (wl_addr[i] & 255) || wl_addr[i] !== i) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL copy_data: %0d bad writes, first #%0d addr=%0d data=%0d", bad, first, wl_addr[first], wl_data[first]); end
        build_exp(2, 0, s, wl_addr.size());
        bad = 0; first = -1;
        foreach (wl_cyc[i]) if (wl_cyc[i] !== exp_cyc[i]) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL copy_timing: %0d bad, first #%0d cyc=%0d want %0d", bad, first, wl_cyc[first], exp_cyc[first]); end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (wl_addr.size() !== NPIX) begin failures++; $display("FAIL copy_count: got %0d want %0d", wl_addr.size(), NPIX); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL copy_done_once: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL copy_no_retrigger_busy: got %b want 0", busy); end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_zoom_in();
        int s, bad, first;
        randomize_rom();
        for (int lvl = 3; lvl <= 4; lvl++) begin
            start_frame(lvl, int'($urandom_range(0, 3)), s);
            repeat (3) @(posedge clk);
            #1;
            enable = 1'b0;
            zoom_level = 3'($urandom_range(0, 1));
            algorithm_select = 2'b11;
            wait_writes(400, 2000);
            checks++;
            if (wl_addr.size() < 400) begin failures++; $display("FAIL zoom_in_%0d_timeout: writes=%0d want 400", lvl, wl_addr.size()); end
            if (lvl == 3) begin
                checks++; if (wl_data[0] !== int'(rom[30*W+40])) begin failures++; $display("FAIL zin_dst00: got %0d want %0d", wl_data[0], rom[30*W+40]); end
                checks++; if (wl_data[1] !== int'(rom[30*W+40])) begin failures++; $display("FAIL zin_dst10: got %0d want %0d", wl_data[1], rom[30*W+40]); end
                checks++; if (wl_data[2] !== int'(rom[30*W+41])) begin failures++; $display("FAIL zin_dst20: got %0d want %0d", wl_data[2], rom[30*W+41]); end
                checks++; if (wl_data[W] !== int'(rom[30*W+40])) begin failures++; $display("FAIL zin_dst01: got %0d want %0d", wl_data[W], rom[30*W+40]); end
            end
            build_exp(lvl, 0, s, wl_addr.size());
            bad = 0; first = -1;
            foreach (wl_addr[i]) if (wl_addr[i] !== exp_addr[i] || wl_data[i] !== exp_data[i] || wl_cyc[i] !== exp_cyc[i]) begin bad++; if (first < 0) first = i; end
            checks++;
            if (bad !== 0) begin failures++; $display("FAIL zin_model_%0d: %0d bad, first #%0d addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d", lvl, bad, first, wl_addr[first], wl_data[first], wl_cyc[first], exp_addr[first], exp_data[first], exp_cyc[first]); end
            abort_frame();
        end
    endtask

    task automatic test_decimate();
        int s, bad, first;
        randomize_rom();
        start_frame(1, 2, s);
        wait_writes(4930, 6000);
        checks++;
        if (wl_addr.size() < 4930) begin failures++; $display("FAIL dec_timeout: writes=%0d want 4930", wl_addr.size()); end
        checks++; if (wl_data[0] !== 0) begin failures++; $display("FAIL dec_dst00: got %0d want 0", wl_data[0]); end
        checks++; if (wl_data[30*W+40] !== int'(rom[0])) begin failures++; $display("FAIL dec_dst40_30: got %0d want %0d", wl_data[30*W+40], rom[0]); end
        checks++; if (wl_data[30*W+41] !== int'(rom[2])) begin failures++; $display("FAIL dec_dst41_30: got %0d want %0d", wl_data[30*W+41], rom[2]); end
        checks++; if (wl_data[30*W+120] !== 0) begin failures++; $display("FAIL dec_dst120_30: got %0d want 0", wl_data[30*W+120]); end
        build_exp(1, 2, s, wl_addr.size());
        bad = 0; first = -1;
        foreach (wl_addr[i]) if (wl_addr[i] !== exp_addr[i] || wl_data[i] !== exp_data[i] || wl_cyc[i] !== exp_cyc[i]) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL dec_model: %0d bad, first #%0d addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d", bad, first, wl_addr[first], wl_data[first], wl_cyc[first], exp_addr[first], exp_data[first], exp_cyc[first]); end
        abort_frame();
    endtask

    task automatic test_block_avg();
        int s, bad, first, wc, want;
        randomize_rom();
        rom[0] = 8'd10; rom[1] = 8'd20; rom[W] = 8'd30; rom[W+1] = 8'd40;
        start_frame(1, 3, s);
        wait_writes(4850, 7000);
        checks++;
        if (wl_addr.size() < 4850) begin failures++; $display("FAIL avg_timeout: writes=%0d want 4850", wl_addr.size()); end
        wc = wl_cyc[30*W+40];
`ifdef ZOOM_ENGINE_AVG_EN
        want = 25;
        checks++;
        if (rd_hist[wc-4] !== 15'd0 || rd_hist[wc-3] !== 15'd1 || rd_hist[wc-2] !== 15'(W) || rd_hist[wc-1] !== 15'(W+1)) begin
            failures++;
            $display("FAIL avg_read_timing: reads %0d %0d %0d %0d before write, want 0 1 %0d %0d", rd_hist[wc-4], rd_hist[wc-3], rd_hist[wc-2], rd_hist[wc-1], W, W+1);
        end
`else
        want = 10;
        checks++;
        if (rd_hist[wc-1] !== 15'd0) begin failures++; $display("FAIL avg_read_timing: read %0d before write, want 0", rd_hist[wc-1]); end
`endif
        checks++; if (wl_data[30*W+40] !== want) begin failures++; $display("FAIL avg_dst40_30: got %0d want %0d", wl_data[30*W+40], want); end
        build_exp(1, 3, s, wl_addr.size());
        bad = 0; first = -1;
        foreach (wl_addr[i]) if (wl_addr[i] !== exp_addr[i] || wl_data[i] !== exp_data[i] || wl_cyc[i] !== exp_cyc[i]) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL avg_model: %0d bad, first #%0d addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d", bad, first, wl_addr[first], wl_data[first], wl_cyc[first], exp_addr[first], exp_data[first], exp_cyc[first]); end
        abort_frame();
    endtask

    task automatic test_quarter();
        int s, s10, bad, first;
        int d10[$], c10[$];
        randomize_rom();
        start_frame(0, 2, s10);
        wait_writes(7400, 9000);
        foreach (wl_data[i]) begin d10.push_back(wl_data[i]); c10.push_back(wl_cyc[i] - s10); end
        abort_frame();
        start_frame(0, 3, s);
        wait_writes(7400, 12000);
        checks++;
        if (wl_addr.size() < 7400) begin failures++; $display("FAIL q_timeout: writes=%0d want 7400", wl_addr.size()); end
        build_exp(0, 3, s, wl_addr.size());
        bad = 0; first = -1;
        foreach (wl_addr[i]) if (wl_addr[i] !== exp_addr[i] || wl_data[i] !== exp_data[i] || wl_cyc[i] !== exp_cyc[i]) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL q_model: %0d bad, first #%0d addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d", bad, first, wl_addr[first], wl_data[first], wl_cyc[first], exp_addr[first], exp_data[first], exp_cyc[first]); end
`ifndef ZOOM_ENGINE_AVG_EN
        bad = 0; first = -1;
        for (int i = 0; i < 7400; i++) if (wl_data[i] !== d10[i] || (wl_cyc[i] - s) !== c10[i]) begin bad++; if (first < 0) first = i; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL q_alg11_vs_alg10: %0d differ, first #%0d data=%0d rel_cyc=%0d want %0d/%0d", bad, first, wl_data[first], wl_cyc[first] - s, d10[first], c10[first]); end
`endif
        abort_frame();
    endtask

    task automatic test_reset_mid();
        int s, n0;
        randomize_rom();
        start_frame(3, 0, s);
        wait_writes(500, 2000);
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_reset_done: got %b want 0", done); end
        n0 = wl_addr.size();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (wl_addr.size() !== n0) begin failures++; $display("FAIL mid_reset_no_writes: got %0d want %0d", wl_addr.size(), n0); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL mid_reset_no_done: got %0d want 0", done_cnt); end
        start_frame(2, 0, s);
        wait_writes(1, 50);
        checks++;
        if (wl_addr.size() < 1 || wl_addr[0] !== 0 || wl_data[0] !== int'(rom[0]) || wl_cyc[0] !== s + 2) begin
            failures++;
            $display("FAIL restart_first_write: n=%0d addr=%0d data=%0d cyc=%0d want addr 0 data %0d cyc %0d", wl_addr.size(), wl_addr[0], wl_data[0], wl_cyc[0], rom[0], s + 2);
        end
        abort_frame();
    endtask

    initial begin
        test_reset();
        test_copy();
        test_zoom_in();
        test_decimate();
        test_block_avg();
        test_quarter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
